// File: rtl/fifo_pkg.sv
// fifo_pkg: read/write FIFO shared state encodings and Gray/binary helpers
// No ports; PTR_MAX bounds the pointer width the helpers accept.
package fifo_pkg;
    localparam int PTR_MAX = 16;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        AVAIL = 2'b01,
        LAST  = 2'b10
    } fifo_state_e;
    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        for (int i = 0; i < PTR_MAX; i++) b[i] = ^(g >> i);
        return b;
    endfunction
endpackage

// File: rtl/fifo_read_logic_if.sv
// fifo_read_logic_if: read-side FIFO bus between consumer/RAM/sync (master) and read logic (slave)
// master drives rinc, rq2_waddr, mem_rdata; slave drives read_en, raddr, raddr_gray,
// rempty, rdata, rvalid, runderflow.
interface fifo_read_logic_if #(
    parameter int PTR_SZ = 2,
    parameter int DW     = 8
);
    logic              rinc;
    logic [PTR_SZ-1:0] rq2_waddr;
    logic [DW-1:0]     mem_rdata;
    logic              read_en;
    logic [PTR_SZ-1:0] raddr;
    logic [PTR_SZ-1:0] raddr_gray;
    logic              rempty;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic              runderflow;
    modport master (
        output rinc, rq2_waddr, mem_rdata,
        input  read_en, raddr, raddr_gray, rempty, rdata, rvalid, runderflow
    );
    modport slave (
        input  rinc, rq2_waddr, mem_rdata,
        output read_en, raddr, raddr_gray, rempty, rdata, rvalid, runderflow
    );
endinterface

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray-to-binary pointer conversion
// gray in PTR_SZ, bin out PTR_SZ.
module fifo_gray2bin #(
    parameter int PTR_SZ = 2
) (
    input  logic [PTR_SZ-1:0] gray,
    output logic [PTR_SZ-1:0] bin
);
    for (genvar i = 0; i < PTR_SZ; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end
endmodule

// File: rtl/fifo_read_logic.sv
// fifo_read_logic: dual-clock FIFO read-side pointer, empty flag and read-data register
// clk, rst (sync active-low) plain ports; all FIFO signals on fifo_read_logic_if.slave bus.
// Optional FIFO_RD_UNDERFLOW_EN adds the sticky runderflow flag; otherwise it is tied 0.
module fifo_read_logic
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_SZ = 2,
    parameter int DW     = 8
) (
    input logic               clk,
    input logic               rst,
    fifo_read_logic_if.slave  bus
);
    logic [PTR_SZ-1:0]        wbin, raddr_q, raddr_d, gray_q, gray_d;
    logic [$clog2(DEPTH)-1:0] occ;
    fifo_state_e              state_q, state_d;
    logic [DW-1:0]            rdata_q, rdata_d;
    logic                     rempty_q, rvalid_q, read_en;
    fifo_gray2bin #(.PTR_SZ(PTR_SZ)) u_g2b (
        .gray (bus.rq2_waddr),
        .bin  (wbin)
    );
    always_comb begin
        read_en = bus.rinc & ~rempty_q;
        raddr_d = raddr_q + PTR_SZ'(read_en);
        gray_d  = PTR_SZ'(bin2gray(PTR_MAX'(raddr_d)));
        occ     = wbin - raddr_d;
        state_d = occ == '0 ? EMPTY : occ == ($clog2(DEPTH))'(1) ? LAST : AVAIL;
        rdata_d = read_en ? bus.mem_rdata : rdata_q;
    end
    // rempty has its own flop so the exported flag never glitches while state bits change
    always_ff @(posedge clk) begin
        if (!rst) begin
            raddr_q  <= '0;
            gray_q   <= '0;
            state_q  <= EMPTY;
            rempty_q <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            raddr_q  <= raddr_d;
            gray_q   <= gray_d;
            state_q  <= state_d;
            rempty_q <= state_d == EMPTY;
            rdata_q  <= rdata_d;
            rvalid_q <= read_en;
        end
    end
`ifdef FIFO_RD_UNDERFLOW_EN
    logic uflow_q, uflow_d;
    always_comb uflow_d = uflow_q | (bus.rinc & rempty_q);
    always_ff @(posedge clk) begin
        if (!rst) uflow_q <= 1'b0;
        else      uflow_q <= uflow_d;
    end
    assign bus.runderflow = uflow_q;
`else
    assign bus.runderflow = 1'b0;
`endif
    assign bus.read_en    = read_en;
    assign bus.raddr      = raddr_q;
    assign bus.raddr_gray = gray_q;
    assign bus.rempty     = rempty_q;
    assign bus.rdata      = rdata_q;
    assign bus.rvalid     = rvalid_q;
endmodule

// File: tb/tb_fifo_read_logic.sv
// tb_fifo_read_logic: randomized self-checking bench for fifo_read_logic against a count-based FIFO model
module tb_fifo_read_logic;
`ifdef FIFO_RD_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] mem [4];
    int tests = 0;
    int fails = 0;
    int wr = 0;
    int rd = 0;
    logic m_rempty = 1'b1, m_rvalid = 1'b0, m_uf = 1'b0, m_ren = 1'b0, obs_ren = 1'b0;
    logic [7:0] m_rdata = '0, pop_data = '0;
    always #5 clk = ~clk;
    fifo_read_logic_if #(.PTR_SZ(2), .DW(8)) bus ();
    fifo_read_logic #(.DEPTH(4), .PTR_SZ(2), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    assign bus.mem_rdata = mem[bus.raddr];
    function automatic logic [1:0] g(input int b);
        return 2'(b ^ (b >> 1));
    endfunction
    function automatic logic [1:0] st(input int occ);
        return occ == 0 ? 2'b00 : occ == 1 ? 2'b10 : 2'b01;
    endfunction
    // one read-domain cycle: optional write-pointer advance, optional pop request, model update
    task automatic tick(input logic inc, input bit wadv);
        @(negedge clk);
        rst = 1'b1;
        if (wadv) begin
            mem[wr % 4] = 8'($urandom);
            wr++;
        end
        bus.rinc = inc;
        bus.rq2_waddr = g(wr % 4);
        #1;
        obs_ren = bus.read_en;
        m_ren = inc && !m_rempty;
        pop_data = mem[rd % 4];
        @(posedge clk);
        #1;
        if (inc && m_rempty) m_uf = UF_EN;
        if (m_ren) begin
            m_rdata = pop_data;
            rd++;
        end
        m_rvalid = m_ren;
        m_rempty = (wr == rd);
    endtask
    task automatic do_reset(input int n, input logic inc);
        @(negedge clk);
        rst = 1'b0;
        bus.rinc = inc;
        repeat (n) @(posedge clk);
        #1;
        rd = 0;
        m_rempty = 1'b1;
        m_rvalid = 1'b0;
        m_rdata = '0;
        m_uf = 1'b0;
    endtask
    task automatic test_reset;
        do_reset(2, 1'b1);
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL reset_rempty got %0h exp 1", bus.rempty); end
        tests++; if (bus.raddr !== 2'd0) begin fails++; $display("FAIL reset_raddr got %0h exp 0", bus.raddr); end
        tests++; if (bus.raddr_gray !== 2'd0) begin fails++; $display("FAIL reset_gray got %0h exp 0", bus.raddr_gray); end
        tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %0h exp 0", bus.rvalid); end
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %0h exp 00", bus.rdata); end
        tests++; if (bus.runderflow !== 1'b0) begin fails++; $display("FAIL reset_uflow got %0h exp 0", bus.runderflow); end
        wr = 0;
    endtask
    task automatic test_single;
        tick(1'b1, 1'b1);
        tests++; if (obs_ren !== 1'b0) begin fails++; $display("FAIL single_ren_empty got %0h exp 0", obs_ren); end
        tests++; if (bus.rempty !== 1'b0) begin fails++; $display("FAIL single_rempty0 got %0h exp 0", bus.rempty); end
        tick(1'b1, 1'b0);
        tests++; if (obs_ren !== 1'b1) begin fails++; $display("FAIL single_ren got %0h exp 1", obs_ren); end
        tests++; if (bus.rdata !== mem[0]) begin fails++; $display("FAIL single_rdata got %0h exp %0h", bus.rdata, mem[0]); end
        tests++; if (bus.rvalid !== 1'b1) begin fails++; $display("FAIL single_rvalid got %0h exp 1", bus.rvalid); end
        tests++; if (bus.raddr !== 2'd1) begin fails++; $display("FAIL single_raddr got %0h exp 1", bus.raddr); end
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL single_rempty1 got %0h exp 1", bus.rempty); end
        tick(1'b1, 1'b0);
        tests++; if (obs_ren !== 1'b0) begin fails++; $display("FAIL single_ren_after got %0h exp 0", obs_ren); end
        tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL single_rvalid_after got %0h exp 0", bus.rvalid); end
    endtask
    task automatic test_wrap;
        int pulses;
        do_reset(1, 1'b0);
        wr = 0;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            tick(1'b1, k < 5);
            pulses += int'(bus.rvalid);
            tests++; if (bus.raddr !== 2'(rd % 4)) begin fails++; $display("FAIL wrap_raddr[%0d] got %0h exp %0h", k, bus.raddr, 2'(rd % 4)); end
            tests++; if (bus.raddr_gray !== g(rd % 4)) begin fails++; $display("FAIL wrap_gray[%0d] got %0h exp %0h", k, bus.raddr_gray, g(rd % 4)); end
            tests++; if (bus.rdata !== m_rdata) begin fails++; $display("FAIL wrap_rdata[%0d] got %0h exp %0h", k, bus.rdata, m_rdata); end
        end
        tests++; if (pulses != 5) begin fails++; $display("FAIL wrap_pulses got %0d exp 5", pulses); end
        tests++; if (bus.raddr !== 2'd1) begin fails++; $display("FAIL wrap_final_raddr got %0h exp 1", bus.raddr); end
    endtask
    task automatic test_empty_pop;
        logic [1:0] a0;
        do_reset(1, 1'b0);
        wr = 0;
        tick(1'b0, 1'b0);
        tests++; if (bus.runderflow !== 1'b0) begin fails++; $display("FAIL empty_uflow_pre got %0h exp 0", bus.runderflow); end
        a0 = bus.raddr;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0);
            tests++; if (obs_ren !== 1'b0) begin fails++; $display("FAIL empty_ren[%0d] got %0h exp 0", k, obs_ren); end
            tests++; if (bus.raddr !== 2'd0) begin fails++; $display("FAIL empty_raddr[%0d] got %0h exp 0 (before %0h)", k, bus.raddr, a0); end
            tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL empty_rvalid[%0d] got %0h exp 0", k, bus.rvalid); end
            tests++; if (bus.runderflow !== UF_EN) begin fails++; $display("FAIL empty_uflow[%0d] got %0h exp %0h", k, bus.runderflow, UF_EN); end
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tests++; if (bus.runderflow !== UF_EN) begin fails++; $display("FAIL empty_uflow_sticky got %0h exp %0h", bus.runderflow, UF_EN); end
    endtask
    task automatic test_simultaneous;
        tick(1'b0, 1'b1);
        tests++; if (2'(dut.state_q) !== st(wr - rd)) begin fails++; $display("FAIL sim_state_pre got %0h exp %0h", 2'(dut.state_q), st(wr - rd)); end
        tick(1'b1, 1'b1);
        tests++; if (obs_ren !== 1'b1) begin fails++; $display("FAIL sim_ren got %0h exp 1", obs_ren); end
        tests++; if (bus.rempty !== 1'b0) begin fails++; $display("FAIL sim_rempty got %0h exp 0", bus.rempty); end
        tests++; if (2'(dut.state_q) !== 2'b10) begin fails++; $display("FAIL sim_state got %0h exp 2", 2'(dut.state_q)); end
        tests++; if (bus.rdata !== m_rdata) begin fails++; $display("FAIL sim_rdata got %0h exp %0h", bus.rdata, m_rdata); end
        tick(1'b1, 1'b0);
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL sim_last_rempty got %0h exp 1", bus.rempty); end
        tests++; if (2'(dut.state_q) !== 2'b00) begin fails++; $display("FAIL sim_last_state got %0h exp 0", 2'(dut.state_q)); end
    endtask
    task automatic test_reset_mid;
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tests++; if (2'(dut.state_q) !== st(wr - rd)) begin fails++; $display("FAIL mid_state_pre got %0h exp %0h", 2'(dut.state_q), st(wr - rd)); end
        tests++; if (bus.rvalid !== 1'b1) begin fails++; $display("FAIL mid_rvalid_pre got %0h exp 1", bus.rvalid); end
        do_reset(1, 1'b1);
        tests++; if (bus.rempty !== 1'b1) begin fails++; $display("FAIL mid_rempty got %0h exp 1", bus.rempty); end
        tests++; if (bus.raddr !== 2'd0) begin fails++; $display("FAIL mid_raddr got %0h exp 0", bus.raddr); end
        tests++; if (bus.raddr_gray !== 2'd0) begin fails++; $display("FAIL mid_gray got %0h exp 0", bus.raddr_gray); end
        tests++; if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL mid_rvalid got %0h exp 0", bus.rvalid); end
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL mid_rdata got %0h exp 00", bus.rdata); end
        tests++; if (bus.runderflow !== 1'b0) begin fails++; $display("FAIL mid_uflow got %0h exp 0", bus.runderflow); end
        wr = 0;
    endtask
    task automatic test_random;
        logic inc;
        bit wadv;
        for (int k = 0; k < 400; k++) begin
            inc = ($urandom_range(0, 3) != 0);
            wadv = (wr - rd < 3) && ($urandom_range(0, 1) == 1);
            tick(inc, wadv);
            tests++; if (obs_ren !== m_ren) begin fails++; $display("FAIL rnd_ren[%0d] got %0h exp %0h", k, obs_ren, m_ren); end
            tests++; if (bus.raddr !== 2'(rd % 4)) begin fails++; $display("FAIL rnd_raddr[%0d] got %0h exp %0h", k, bus.raddr, 2'(rd % 4)); end
            tests++; if (bus.raddr_gray !== g(rd % 4)) begin fails++; $display("FAIL rnd_gray[%0d] got %0h exp %0h", k, bus.raddr_gray, g(rd % 4)); end
            tests++; if (bus.rempty !== m_rempty) begin fails++; $display("FAIL rnd_rempty[%0d] got %0h exp %0h", k, bus.rempty, m_rempty); end
            tests++; if (bus.rvalid !== m_rvalid) begin fails++; $display("FAIL rnd_rvalid[%0d] got %0h exp %0h", k, bus.rvalid, m_rvalid); end
            tests++; if (bus.rdata !== m_rdata) begin fails++; $display("FAIL rnd_rdata[%0d] got %0h exp %0h", k, bus.rdata, m_rdata); end
            tests++; if (bus.runderflow !== m_uf) begin fails++; $display("FAIL rnd_uflow[%0d] got %0h exp %0h", k, bus.runderflow, m_uf); end
            tests++; if (2'(dut.state_q) !== st(wr - rd)) begin fails++; $display("FAIL rnd_state[%0d] got %0h exp %0h", k, 2'(dut.state_q), st(wr - rd)); end
        end
    endtask
    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        bus.rinc = 1'b0;
        bus.rq2_waddr = 2'b00;
        test_reset();
        test_single();
        test_wrap();
        test_empty_pop();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
